// File: rtl/conv_maxpool_2x2_if.sv
// Stream bundle between the convolution stage and the 2x2 max-pool.
// Handshake: valid-only. A beat transfers on every rising edge where the
// valid bit is high; there is no ready and no backpressure.
interface conv_maxpool_2x2_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         In_Valid;
    logic signed [DATA_WIDTH-1:0] In_Data;
    logic                         Out_Valid;
    logic signed [DATA_WIDTH-1:0] Out_Data;
    logic                         Row_Last;

    modport master (
        output In_Valid,
        output In_Data,
        input  Out_Valid,
        input  Out_Data,
        input  Row_Last
    );

    modport slave (
        input  In_Valid,
        input  In_Data,
        output Out_Valid,
        output Out_Data,
        output Row_Last
    );
endinterface

// File: rtl/conv_maxpool_2x2.sv
// 2x2 stride-2 max-pool over a streamed conv output map.
// Pairs of columns are reduced in a pair register. Even rows park their
// pair maxima in a half-row line buffer, and odd rows combine with it to
// emit one pooled pixel per window.
// Optional build macro POOL_RELU_EN fuses a ReLU into the output register.
module conv_maxpool_2x2 #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_LEN    = 98,
    parameter int CNT_WIDTH  = 7
) (
    input logic              Clk,
    input logic              Rst,
    conv_maxpool_2x2_if.slave bus
);
    localparam int HALF_LEN = ROW_LEN / 2;
    localparam int ADDR_W   = CNT_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(ROW_LEN - 1);

    logic [CNT_WIDTH-1:0]         col;
    logic                         odd_row;
    logic signed [DATA_WIDTH-1:0] pair_hold;
    logic signed [DATA_WIDTH-1:0] line_buf [HALF_LEN];

    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         row_last;

    logic [ADDR_W-1:0]            buf_addr;
    logic signed [DATA_WIDTH-1:0] buf_rd;
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [DATA_WIDTH-1:0] pooled;
    logic signed [DATA_WIDTH-1:0] pooled_out;
    logic                         col_end;
    logic                         odd_col;

    // Pair and window maxima, line buffer addressing, optional ReLU.
    always_comb begin
        buf_addr = col[CNT_WIDTH-1:1];
        buf_rd   = line_buf[buf_addr];
        odd_col  = col[0];
        col_end  = (col == COL_LAST);
        pair_max = ($signed(pair_hold) > $signed(bus.In_Data)) ? pair_hold : bus.In_Data;
        pooled   = ($signed(buf_rd) > $signed(pair_max)) ? buf_rd : pair_max;
`ifdef POOL_RELU_EN
        pooled_out = (pooled < 0) ? '0 : pooled;
`else
        pooled_out = pooled;
`endif
    end

    // Column position, row parity and the even-column pair register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            col       <= '0;
            odd_row   <= 1'b0;
            pair_hold <= '0;
        end else if (bus.In_Valid) begin
            if (!odd_col) begin
                pair_hold <= bus.In_Data;
            end
            if (col_end) begin
                col     <= '0;
                odd_row <= ~odd_row;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Even rows store their pair maxima; no reset, an even row always
    // rewrites every entry before an odd row reads it.
    always_ff @(posedge Clk) begin
        if (!Rst && bus.In_Valid && odd_col && !odd_row) begin
            line_buf[buf_addr] <= pair_max;
        end
    end

    // Output register: single-cycle strobes, data held between strobes.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            row_last  <= 1'b0;
        end else if (bus.In_Valid && odd_col && odd_row) begin
            out_valid <= 1'b1;
            out_data  <= pooled_out;
            row_last  <= col_end;
        end else begin
            out_valid <= 1'b0;
            row_last  <= 1'b0;
        end
    end

    assign bus.Out_Valid = out_valid;
    assign bus.Out_Data  = out_data;
    assign bus.Row_Last  = row_last;
endmodule

// File: tb/tb_conv_maxpool_2x2.sv
// Testbench for conv_maxpool_2x2: a full-size instance checked cycle by
// cycle against a row-array model, plus a ROW_LEN=2 instance for small
// hand-computed windows. Honours POOL_RELU_EN like the design.
module tb_conv_maxpool_2x2;
  localparam int DW = 16;
  localparam int RL = 98;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 rst2 = 1'b0;
  logic                 s_valid = 1'b0;
  logic signed [DW-1:0] s_data = '0;

  conv_maxpool_2x2_if #(.DATA_WIDTH(DW)) m_if ();
  conv_maxpool_2x2_if #(.DATA_WIDTH(DW)) s_if ();

  assign m_if.In_Valid = in_valid;
  assign m_if.In_Data  = in_data;
  assign s_if.In_Valid = s_valid;
  assign s_if.In_Data  = s_data;

  conv_maxpool_2x2 #(.DATA_WIDTH(DW), .ROW_LEN(RL), .CNT_WIDTH(7)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (m_if.slave)
  );

  conv_maxpool_2x2 #(.DATA_WIDTH(DW), .ROW_LEN(2), .CNT_WIDTH(2)) dut_small (
    .Clk (clk),
    .Rst (rst2),
    .bus (s_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- model ----------------
  function automatic logic signed [DW-1:0] max2(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef POOL_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  logic signed [DW-1:0] prev_row [RL];
  logic signed [DW-1:0] cur_row  [RL];
  int                   m_col = 0;
  int                   m_row = 0;
  logic                 exp_valid = 1'b0;
  logic                 exp_last = 1'b0;
  logic signed [DW-1:0] exp_hold = '0;
  logic [DW-1:0]        exp_q[$];
  logic                 chk_en = 1'b0;

  // Window maxima from whole stored rows: when the odd row reaches an odd
  // column, the window is the 2x2 block ending at (m_row, m_col).
  always @(posedge clk) begin
    if (rst) begin
      m_col = 0;
      m_row = 0;
      exp_valid = 1'b0;
      exp_last = 1'b0;
      exp_hold = '0;
      exp_q.delete();
    end else if (in_valid) begin
      cur_row[m_col] = in_data;
      exp_valid = 1'b0;
      exp_last = 1'b0;
      if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
        exp_q.push_back(relu(max2(max2(prev_row[m_col-1], prev_row[m_col]),
                                  max2(cur_row[m_col-1], cur_row[m_col]))));
        exp_valid = 1'b1;
        exp_last = (m_col == RL - 1);
      end
      if (m_col == RL - 1) begin
        prev_row = cur_row;
        m_col = 0;
        m_row++;
      end else begin
        m_col++;
      end
    end else begin
      exp_valid = 1'b0;
      exp_last = 1'b0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  int                   obs_cnt = 0;
  int                   obs_rl = 0;
  logic signed [DW-1:0] obs_first = '0;
  logic signed [DW-1:0] obs_lastv = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (m_if.Out_Valid !== exp_valid) begin
        n_err++;
        $display("FAIL out_valid: got %b want %b at %0t", m_if.Out_Valid, exp_valid, $time);
      end
      if (exp_valid && exp_q.size() > 0) exp_hold = exp_q.pop_front();
      n_vec++;
      if (m_if.Out_Data !== exp_hold) begin
        n_err++;
        $display("FAIL out_data: got %0d want %0d at %0t", m_if.Out_Data, exp_hold, $time);
      end
      n_vec++;
      if (m_if.Row_Last !== exp_last) begin
        n_err++;
        $display("FAIL row_last: got %b want %b at %0t", m_if.Row_Last, exp_last, $time);
      end
      if (m_if.Out_Valid === 1'b1) begin
        obs_cnt++;
        if (obs_cnt == 1) obs_first = m_if.Out_Data;
        obs_lastv = m_if.Out_Data;
        if (m_if.Row_Last === 1'b1) obs_rl++;
      end
    end
  end

  int s_cnt = 0;
  always @(posedge clk) if (s_if.Out_Valid === 1'b1) s_cnt++;

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic signed [DW-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = DW'($urandom_range(0, 65535));
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (cycles - 1) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic clear_obs();
    obs_cnt = 0;
    obs_rl = 0;
    obs_first = '0;
    obs_lastv = '0;
  endtask

  task automatic send2(input logic signed [DW-1:0] d, input int gaps);
    @(negedge clk);
    s_valid = 1'b1;
    s_data = d;
    repeat (gaps) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  // ---------------- small instance: hand-computed windows ----------------
  task automatic run_small();
    logic signed [DW-1:0] neg_want;
    int base;
`ifdef POOL_RELU_EN
    neg_want = '0;
`else
    neg_want = -16'sd2;
`endif
    @(negedge clk);
    rst2 = 1'b1;
    s_valid = 1'b1;
    s_data = 16'sd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("small_reset_valid", int'(s_if.Out_Valid), 0);
      check("small_reset_data", int'(s_if.Out_Data), 0);
      check("small_reset_last", int'(s_if.Row_Last), 0);
    end
    rst2 = 1'b0;
    s_valid = 1'b0;

    // 3,-5 / 7,1 -> 7, strobe one cycle after the fourth input
    base = s_cnt;
    send2(16'sd3, 0);
    send2(-16'sd5, 0);
    send2(16'sd7, 0);
    send2(16'sd1, 0);
    @(negedge clk);
    s_valid = 1'b0;
    check("win_valid", int'(s_if.Out_Valid), 1);
    check("win_data", int'(s_if.Out_Data), 7);
    check("win_last", int'(s_if.Row_Last), 1);
    @(negedge clk);
    check("win_strobe_width", int'(s_if.Out_Valid), 0);
    check("win_hold", int'(s_if.Out_Data), 7);

    // all negative -> -2, or 0 with ReLU
    send2(-16'sd4, 0);
    send2(-16'sd9, 0);
    send2(-16'sd2, 0);
    send2(-16'sd6, 0);
    @(negedge clk);
    s_valid = 1'b0;
    check("neg_valid", int'(s_if.Out_Valid), 1);
    check("neg_data", int'(s_if.Out_Data), int'(neg_want));

    // same window as the first, two idle cycles around every pixel
    send2(16'sd3, 2);
    send2(-16'sd5, 2);
    send2(16'sd7, 2);
    send2(16'sd1, 3);
    check("bubble_data", int'(s_if.Out_Data), 7);
    check("small_strobes", s_cnt - base, 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    run_small();

    do_reset(3);

    // full ramp frame
    clear_obs();
    for (int r = 0; r < RL; r++)
      for (int c = 0; c < RL; c++)
        send(DW'(r * 100 + c));
    idle(3);
    check("frame_strobes", obs_cnt, 2401);
    check("frame_first", int'(obs_first), 101);
    check("frame_last", int'(obs_lastv), 9797);
    check("frame_row_last", obs_rl, 49);

    // random signed data with random bubbles
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < RL; c++) begin
        send(DW'($urandom_range(0, 65535)));
        idle($urandom_range(0, 2));
      end
    idle(2);

    // reset part-way through row 1, then a fresh block
    for (int c = 0; c < RL; c++) send(DW'(7000 + c));
    for (int c = 0; c < 37; c++) send(DW'(8000 + c));
    do_reset(1);
    clear_obs();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < RL; c++)
        send(DW'(r * 100 + c + 500));
    idle(3);
    check("fresh_strobes", obs_cnt, 49);
    check("fresh_first", int'(obs_first), 601);
    check("fresh_last", int'(obs_lastv), 697);
    check("fresh_row_last", obs_rl, 1);

    // a trailing even-index row alone produces nothing
    clear_obs();
    for (int c = 0; c < RL; c++) send(DW'(c));
    idle(3);
    check("lone_row_strobes", obs_cnt, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/conv_maxpool_2x2.md
# conv_maxpool_2x2

Downstream consumer of the convolution stage's output stream. Accepts one conv result per cycle qualified by the column-valid strobe, applies a 2x2 stride-2 max-pool using a single half-row line buffer, and emits one pooled pixel per 2x2 window. With defaults it reduces a 98x98 conv output map to 49x49. The output stream feeds the next layer's input buffer.

## Interface

- DATA_WIDTH, 16, width of signed two's-complement conv results and pooled outputs
- ROW_LEN, 98, valid conv outputs per row; must be even and at least 2
- CNT_WIDTH, 7, column counter width; must satisfy 2^CNT_WIDTH > ROW_LEN

- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- In_Valid  in  1  qualifies In_Data; driven by the conv column-valid strobe ANDed with the row-valid strobe
- In_Data  in  DATA_WIDTH  signed conv result
- Out_Valid  out  1  one-cycle strobe, pooled pixel on Out_Data
- Out_Data  out  DATA_WIDTH  signed pooled result, held between strobes
- Row_Last  out  1  asserted with Out_Valid on the last pooled pixel of a pooled row

## Operation

- State: column counter Col (0..ROW_LEN-1), row parity Odd_Row, pair register Pair_Hold, line buffer Line_Buf of ROW_LEN/2 entries, output registers.
- Cycles with In_Valid=0 change no state; Out_Valid drops to 0.
- On each In_Valid=1 cycle:
  - Col[0]=0 (even column): Pair_Hold <= In_Data.
  - Col[0]=1 (odd column): Pair_Max = signed max(Pair_Hold, In_Data).
    - Odd_Row=0: Line_Buf[Col>>1] <= Pair_Max.
    - Odd_Row=1: Out_Data <= signed max(Line_Buf[Col>>1], Pair_Max); Out_Valid <= 1; Row_Last <= (Col == ROW_LEN-1).
  - Col == ROW_LEN-1: Col <= 0 and Odd_Row toggles. Otherwise Col <= Col+1.
- Max comparisons are signed. On equality either operand is returned; the values are identical. No width growth.
- Line_Buf is not reset. An even row fully overwrites it before the following odd row reads any entry.
- Outputs per 2 input rows: ROW_LEN/2 pooled pixels. Pooled row count equals input rows/2. A trailing odd input row produces no output.

## Timing

- Reset values: Out_Valid=0, Out_Data=0, Row_Last=0, Col=0, Odd_Row=0, Pair_Hold=0.
- Rst takes precedence over In_Valid. Asserting Rst mid-row or mid-pair discards the partial pair, the partial row, and any stored even row. The first In_Valid after reset is treated as row 0, column 0.
- Latency: Out_Valid asserts on the clock edge that captures the odd-row, odd-column input. Out_Data is visible the cycle after that input is presented.
- Out_Valid and Row_Last are single-cycle strobes even when In_Valid stays high.
- Line_Buf read and write share the same address in the same cycle only across rows, never within a cycle. A single-port register array or inferred RAM with combinational read is acceptable.
- Gaps in In_Valid at any point, including between the two pixels of a pair, are tolerated. Throughput is one input per cycle, with no backpressure.

## Configuration

- POOL_RELU_EN
  - Defined: Out_Data <= (pooled < 0) ? 0 : pooled. ReLU is fused at the output register, with no added latency.
  - Undefined: Out_Data is the raw signed pooled max.
  - Internal pooling and Line_Buf contents are identical in both builds.

## Test plan

- Reset: hold Rst=1 for 3 cycles with In_Valid=1 -> Out_Valid=0, Out_Data=0, Row_Last=0 throughout.
- Single window, ROW_LEN=2: inputs 3, -5 (row 0), then 7, 1 (row 1) -> one Out_Valid with Out_Data=7 and Row_Last=1, one cycle after the fourth input.
- Full frame, default params: 98 rows of ramp data In_Data=row*100+col -> 2401 strobes. The first pooled value is 101 and the last is 9797. Row_Last fires 49 times.
- Bubbles: the same 2x2 window with In_Valid low for 2 cycles between every pixel -> the same result 7, and no extra strobes.
- Negative data, all inputs -4, -9, -2, -6 -> 4-value window yields -2 without POOL_RELU_EN and 0 with it.
- Mid-row reset: pulse Rst after 37 pixels of row 1, then stream a fresh 2-row block -> outputs match a clean run. No stale row-0 values appear.
